// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: sequencer in front of the 4-bit nibble ALU.
// It accepts one 8-bit op request and steps the ALU through load-A, load-B,
// a low-nibble pass and a high-nibble pass. It then returns the byte result
// and the {Z,N,H,C} flag register.
// Optional feature macro: SM83_ALU_SEQ_INCDEC_EN enables INC/DEC (ops 8/9).
// Without the macro, ops 8/9 behave as unused codes.
module sm83_alu_seq #(
    parameter int         ALU_WIDTH = 4,
    parameter logic [3:0] F_RESET   = 4'b0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [2*ALU_WIDTH-1:0] req_a,
    input  logic [2*ALU_WIDTH-1:0] req_b,
    output logic                   resp_valid,
    output logic [2*ALU_WIDTH-1:0] resp_result,
    output logic [3:0]             f_out,
    output logic [2*ALU_WIDTH-1:0] alu_din,
    output logic                   alu_load_a,
    output logic                   alu_load_b,
    output logic                   alu_load_b_zero,
    output logic                   alu_shift_oe,
    output logic                   alu_result_oe,
    output logic                   alu_op_low,
    output logic                   alu_op_b_high,
    output logic                   alu_carry_in,
    output logic                   alu_no_carry_out,
    output logic                   alu_force_carry,
    output logic                   alu_ignore_carry,
    output logic                   alu_negate,
    input  logic [2*ALU_WIDTH-1:0] alu_dout,
    input  logic                   alu_carry,
    input  logic                   alu_zero
);

    localparam int W = 2 * ALU_WIDTH;

`ifdef SM83_ALU_SEQ_INCDEC_EN
    localparam logic INCDEC_EN = 1'b1;
`else
    localparam logic INCDEC_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                           OP_AND = 4'd4, OP_XOR = 4'd5, OP_OR  = 4'd6, OP_CP  = 4'd7,
                           OP_INC = 4'd8, OP_DEC = 4'd9;

    typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_LO, S_HI} state_t;

    state_t         state, state_n;
    logic [3:0]     op_q;
    logic [W-1:0]   b_q;
    logic           lo_carry;
    logic           is_incdec;
    logic [4:0]     ctl;

    logic           req_ready_n, resp_valid_n;
    logic [W-1:0]   result_n, din_n;
    logic [3:0]     f_n;
    logic           load_a_n, load_b_n, load_bz_n, shift_oe_n, result_oe_n;
    logic           op_low_n, op_b_high_n, carry_in_n, r_n, s_n, v_n, neg_n;

    // ALU control word for an op: {no_carry_out, force_carry, ignore_carry, negate, low carry_in}
    function automatic logic [4:0] op_ctl(input logic [3:0] op, input logic c);
        logic [4:0] k;
        k = 5'b00000;
        case (op)
            OP_ADD:          k = 5'b00000;
            OP_ADC:          k = {4'b0000, c};
            OP_SUB, OP_CP:   k = 5'b00011;
            OP_SBC:          k = {4'b0001, ~c};
            OP_XOR:          k = 5'b10000;
            OP_OR:           k = 5'b10100;
            OP_AND:          k = 5'b01001;
            OP_INC:          k = INCDEC_EN ? 5'b00001 : 5'b00000;
            OP_DEC:          k = INCDEC_EN ? 5'b00010 : 5'b00000;
            default:         k = 5'b00000;
        endcase
        return k;
    endfunction

    assign is_incdec = INCDEC_EN && ((op_q == OP_INC) || (op_q == OP_DEC));
    assign ctl       = op_ctl(op_q, f_out[0]);

    // Next state and next values of every registered output
    always_comb begin
        state_n      = state;
        req_ready_n  = 1'b0;
        resp_valid_n = 1'b0;
        result_n     = resp_result;
        f_n          = f_out;
        din_n        = '0;
        load_a_n     = 1'b0;
        load_b_n     = 1'b0;
        load_bz_n    = 1'b0;
        shift_oe_n   = 1'b0;
        result_oe_n  = 1'b0;
        op_low_n     = 1'b0;
        op_b_high_n  = 1'b0;
        carry_in_n   = 1'b0;
        r_n          = 1'b0;
        s_n          = 1'b0;
        v_n          = 1'b0;
        neg_n        = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n    = S_LDA;
                    din_n      = req_a;
                    shift_oe_n = 1'b1;
                    load_a_n   = 1'b1;
                end else begin
                    req_ready_n = 1'b1;
                end
            end
            S_LDA: begin
                state_n = S_LDB;
                if (is_incdec) begin
                    load_bz_n = 1'b1;
                end else begin
                    din_n      = b_q;
                    shift_oe_n = 1'b1;
                    load_b_n   = 1'b1;
                end
            end
            S_LDB: begin
                state_n  = S_LO;
                op_low_n = 1'b1;
                {r_n, s_n, v_n, neg_n, carry_in_n} = ctl;
            end
            S_LO: begin
                state_n     = S_HI;
                op_b_high_n = 1'b1;
                result_oe_n = 1'b1;
                {r_n, s_n, v_n, neg_n} = ctl[4:1];
                // The high pass continues the chain from the low-nibble carry
                carry_in_n  = alu_carry;
            end
            S_HI: begin
                state_n      = S_IDLE;
                req_ready_n  = 1'b1;
                resp_valid_n = 1'b1;
                case (op_q)
                    OP_ADD, OP_ADC: begin
                        result_n = alu_dout;
                        f_n      = {alu_zero, 1'b0, lo_carry, alu_carry};
                    end
                    OP_SUB, OP_SBC: begin
                        result_n = alu_dout;
                        f_n      = {alu_zero, 1'b1, ~lo_carry, ~alu_carry};
                    end
                    OP_CP:  f_n = {alu_zero, 1'b1, ~lo_carry, ~alu_carry};
                    OP_AND: begin
                        result_n = alu_dout;
                        f_n      = {alu_zero, 3'b010};
                    end
                    OP_XOR, OP_OR: begin
                        result_n = alu_dout;
                        f_n      = {alu_zero, 3'b000};
                    end
                    OP_INC: if (INCDEC_EN) begin
                        result_n = alu_dout;
                        f_n      = {alu_zero, 1'b0, lo_carry, f_out[0]};
                    end
                    OP_DEC: if (INCDEC_EN) begin
                        result_n = alu_dout;
                        f_n      = {alu_zero, 1'b1, ~lo_carry, f_out[0]};
                    end
                    default: ;
                endcase
            end
            default: begin
                state_n     = S_IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    // State and all outputs are registered; reset aborts any op in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_result      <= '0;
            f_out            <= F_RESET;
            alu_din          <= '0;
            alu_load_a       <= 1'b0;
            alu_load_b       <= 1'b0;
            alu_load_b_zero  <= 1'b0;
            alu_shift_oe     <= 1'b0;
            alu_result_oe    <= 1'b0;
            alu_op_low       <= 1'b0;
            alu_op_b_high    <= 1'b0;
            alu_carry_in     <= 1'b0;
            alu_no_carry_out <= 1'b0;
            alu_force_carry  <= 1'b0;
            alu_ignore_carry <= 1'b0;
            alu_negate       <= 1'b0;
        end else begin
            state            <= state_n;
            req_ready        <= req_ready_n;
            resp_valid       <= resp_valid_n;
            resp_result      <= result_n;
            f_out            <= f_n;
            alu_din          <= din_n;
            alu_load_a       <= load_a_n;
            alu_load_b       <= load_b_n;
            alu_load_b_zero  <= load_bz_n;
            alu_shift_oe     <= shift_oe_n;
            alu_result_oe    <= result_oe_n;
            alu_op_low       <= op_low_n;
            alu_op_b_high    <= op_b_high_n;
            alu_carry_in     <= carry_in_n;
            alu_no_carry_out <= r_n;
            alu_force_carry  <= s_n;
            alu_ignore_carry <= v_n;
            alu_negate       <= neg_n;
        end
    end

    // Request latch on accept, plus the low-nibble carry captured as LO ends
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            op_q <= req_op;
            b_q  <= req_b;
        end
        if (state == S_LO) begin
            lo_carry <= alu_carry;
        end
    end

endmodule
